gpu_rect_store: RTL and testbench

GPU_RECT_STORE -- requirements
Module: gpu_rect_store

---
 rtl/gpu_rect_store.sv | 114 +++++++++++
 tb/tb_gpu_rect_store.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_rect_store.sv
// gpu_rect_store: receives a rect table (left, top, right, bottom, color
// per slot) as a 16-bit word stream and flags every slot hit by a query.
// Ports: clk, reset (async, active-high), copy_start, mem_din[15:0],
// sel_y, coord -> busy, finish (1-cycle pulse), collisions, colors.
module gpu_rect_store #(
  parameter int COORD_WIDTH      = 10,
  parameter int RECT_COUNT       = 64,
  parameter int RECT_COUNT_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       copy_start,
  input  logic [15:0]                mem_din,
  input  logic                       sel_y,
  input  logic [COORD_WIDTH-1:0]     coord,
  output logic                       busy,
  output logic                       finish,
  output logic [RECT_COUNT-1:0]      collisions,
  output logic [RECT_COUNT*16-1:0]   colors
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  localparam logic [RECT_COUNT_WIDTH-1:0] LAST_SLOT =
    RECT_COUNT_WIDTH'(RECT_COUNT - 1);

  localparam logic [2:0] F_LEFT   = 3'd0;
  localparam logic [2:0] F_TOP    = 3'd1;
  localparam logic [2:0] F_RIGHT  = 3'd2;
  localparam logic [2:0] F_BOTTOM = 3'd3;
  localparam logic [2:0] F_COLOR  = 3'd4;

  state_t                      state;
  logic [2:0]                  field_cnt;
  logic [RECT_COUNT_WIDTH-1:0] slot_cnt;

  logic [COORD_WIDTH-1:0] left_q   [RECT_COUNT];
  logic [COORD_WIDTH-1:0] top_q    [RECT_COUNT];
  logic [COORD_WIDTH-1:0] right_q  [RECT_COUNT];
  logic [COORD_WIDTH-1:0] bottom_q [RECT_COUNT];
  logic [15:0]            color_q  [RECT_COUNT];

  assign busy = (state == RECV);

  // Sequencer: one word per clock while in RECV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      field_cnt <= '0;
      slot_cnt  <= '0;
      finish    <= 1'b0;
    end else begin
      finish <= 1'b0;
      unique case (state)
        IDLE: begin
          if (copy_start) begin
            state     <= RECV;
            field_cnt <= '0;
            slot_cnt  <= '0;
          end
        end
        RECV: begin
          if (field_cnt == F_COLOR) begin
            field_cnt <= '0;
            slot_cnt  <= slot_cnt + 1'b1;
            if (slot_cnt == LAST_SLOT) begin
              state  <= IDLE;
              finish <= 1'b1;
            end
          end else begin
            field_cnt <= field_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table storage; coordinates keep only the low COORD_WIDTH bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RECT_COUNT; i++) begin
        left_q[i]   <= '0;
        top_q[i]    <= '0;
        right_q[i]  <= '0;
        bottom_q[i] <= '0;
        color_q[i]  <= '0;
      end
    end else if (state == RECV) begin
      unique case (field_cnt)
        F_LEFT:   left_q[slot_cnt]   <= mem_din[COORD_WIDTH-1:0];
        F_TOP:    top_q[slot_cnt]    <= mem_din[COORD_WIDTH-1:0];
        F_RIGHT:  right_q[slot_cnt]  <= mem_din[COORD_WIDTH-1:0];
        F_BOTTOM: bottom_q[slot_cnt] <= mem_din[COORD_WIDTH-1:0];
        F_COLOR:  color_q[slot_cnt]  <= mem_din;
        default: ;
      endcase
    end
  end

  // Half-open interval test per slot; lo >= hi can never hit.
  for (genvar i = 0; i < RECT_COUNT; i++) begin : g_slot
    logic [COORD_WIDTH-1:0] lo;
    logic [COORD_WIDTH-1:0] hi;
    assign lo = sel_y ? top_q[i]    : left_q[i];
    assign hi = sel_y ? bottom_q[i] : right_q[i];
    assign collisions[i] = (lo <= coord) && (coord < hi);
    assign colors[16*i +: 16] = color_q[i];
  end

endmodule

// File: tb/tb_gpu_rect_store.sv
// tb_gpu_rect_store: randomized and directed checks of gpu_rect_store
// against a word-indexed table model.
module tb_gpu_rect_store;

  localparam int CW = 10;
  localparam int N  = 64;
  localparam int NW = N * 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            copy_start;
  logic [15:0]     mem_din;
  logic            sel_y;
  logic [CW-1:0]   coord;
  logic            busy;
  logic            finish;
  logic [N-1:0]    collisions;
  logic [N*16-1:0] colors;

  int total = 0;
  int bad   = 0;

  logic [15:0] w [NW];
  int m_l [N];
  int m_t [N];
  int m_r [N];
  int m_b [N];
  int m_c [N];

  gpu_rect_store #(
    .COORD_WIDTH(CW),
    .RECT_COUNT(N),
    .RECT_COUNT_WIDTH(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .copy_start(copy_start),
    .mem_din(mem_din),
    .sel_y(sel_y),
    .coord(coord),
    .busy(busy),
    .finish(finish),
    .collisions(collisions),
    .colors(colors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_l[i] = 0; m_t[i] = 0; m_r[i] = 0; m_b[i] = 0; m_c[i] = 0;
    end
  endtask

  // Word k of the stream belongs to slot k/5, field k%5.
  task automatic model_load();
    for (int k = 0; k < NW; k++) begin
      int s;
      int v;
      s = k / 5;
      v = int'(w[k]) % (1 << CW);
      case (k % 5)
        0: m_l[s] = v;
        1: m_t[s] = v;
        2: m_r[s] = v;
        3: m_b[s] = v;
        default: m_c[s] = int'(w[k]);
      endcase
    end
  endtask

  function automatic logic [N-1:0] exp_hits(input logic sy, input int c);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      int lo;
      int hi;
      lo = sy ? m_t[i] : m_l[i];
      hi = sy ? m_b[i] : m_r[i];
      r[i] = (lo <= c) && (c < hi);
    end
    return r;
  endfunction

  task automatic query(input string tag, input logic sy, input int c);
    sel_y = sy;
    coord = c[CW-1:0];
    #1;
    check(tag, 64'(collisions), 64'(exp_hits(sy, c)));
  endtask

  task automatic query_lit(input string tag, input logic sy, input int c,
                           input logic [63:0] exp);
    sel_y = sy;
    coord = c[CW-1:0];
    #1;
    check(tag, 64'(collisions), exp);
  endtask

  task automatic check_colors(input string tag);
    for (int i = 0; i < N; i++)
      check(tag, 64'(colors[16*i +: 16]), 64'(m_c[i]));
  endtask

  task automatic rand_queries(input string tag, input int n);
    for (int q = 0; q < n; q++)
      query(tag, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
  endtask

  task automatic fill_zero();
    for (int k = 0; k < NW; k++) w[k] = '0;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NW; k++) w[k] = 16'($urandom);
  endtask

  // Streams w[] into the DUT. pulse_at: word index carrying a stray
  // copy_start; reset_at: word index where reset aborts the copy;
  // chain: raise copy_start in the finish cycle to start the next copy.
  task automatic run_copy(input bit skip_start, input int pulse_at,
                          input int reset_at, input bit chain);
    if (!skip_start) begin
      copy_start = 1'b1;
      tick();
      check("busy_start", 64'(busy), 64'd1);
      copy_start = 1'b0;
    end
    for (int k = 0; k < NW; k++) begin
      mem_din    = w[k];
      copy_start = (k == pulse_at);
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        model_clear();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_fin", 64'(finish), 64'd0);
        check("rst_mid_hits", 64'(collisions), 64'd0);
        check_colors("rst_mid_col");
        reset      = 1'b0;
        copy_start = 1'b0;
        return;
      end
      tick();
      if (k == 0 || k == pulse_at || k == NW - 2) begin
        check("busy_mid", 64'(busy), 64'd1);
        check("fin_mid", 64'(finish), 64'd0);
      end
      if (k == NW - 1) begin
        check("busy_end", 64'(busy), 64'd0);
        check("fin_end", 64'(finish), 64'd1);
      end
    end
    copy_start = 1'b0;
    model_load();
    if (chain) begin
      copy_start = 1'b1;
      tick();
      check("chain_busy", 64'(busy), 64'd1);
      check("chain_fin", 64'(finish), 64'd0);
      copy_start = 1'b0;
    end else begin
      tick();
      check("fin_drop", 64'(finish), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    copy_start = 1'b0;
    mem_din    = '0;
    sel_y      = 1'b0;
    coord      = '0;
    model_clear();
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fin", 64'(finish), 64'd0);
    check("rst_hits", 64'(collisions), 64'd0);
    check_colors("rst_col");
    tick();
    reset = 1'b0;
    tick();

    // Single rect in slot 0.
    fill_zero();
    w[0] = 16'd10; w[1] = 16'd20; w[2] = 16'd30; w[3] = 16'd40;
    w[4] = 16'hF800;
    run_copy(1'b0, -1, -1, 1'b0);
    query_lit("x10", 1'b0, 10, 64'd1);
    query_lit("x29", 1'b0, 29, 64'd1);
    query_lit("x30", 1'b0, 30, 64'd0);
    query_lit("x9", 1'b0, 9, 64'd0);
    query_lit("y39", 1'b1, 39, 64'd1);
    query_lit("y40", 1'b1, 40, 64'd0);
    check("col0", 64'(colors[15:0]), 64'hF800);

    // Truncation of coordinate words.
    fill_zero();
    w[0] = 16'hFC0A; w[2] = 16'h000B; w[3] = 16'd1; w[4] = 16'hFC0A;
    run_copy(1'b0, -1, -1, 1'b0);
    query_lit("trunc10", 1'b0, 10, 64'd1);
    query_lit("trunc9", 1'b0, 9, 64'd0);
    check("trunc_col", 64'(colors[15:0]), 64'hFC0A);

    // Full-range rect in the last slot.
    fill_zero();
    w[317] = 16'd1023; w[318] = 16'd1023; w[319] = 16'h1234;
    run_copy(1'b0, -1, -1, 1'b0);
    query_lit("s63x", 1'b0, 500, 64'h8000_0000_0000_0000);
    query_lit("s63y", 1'b1, 500, 64'h8000_0000_0000_0000);
    check("s63col", 64'(colors[1023:1008]), 64'h1234);

    // Random table, stray copy_start, then a back-to-back copy.
    fill_rand();
    run_copy(1'b0, 100, -1, 1'b1);
    fill_rand();
    run_copy(1'b1, -1, -1, 1'b0);
    rand_queries("rnd_a", 30);
    check_colors("rnd_a_col");

    // Reset mid-copy, then a clean copy.
    fill_rand();
    run_copy(1'b0, -1, 100, 1'b0);
    rand_queries("rst_q", 5);
    tick();
    fill_rand();
    run_copy(1'b0, -1, -1, 1'b0);
    rand_queries("rnd_b", 30);
    check_colors("rnd_b_col");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
